// File: rtl/glb_cfg_req_arbiter.sv
// glb_cfg_req_arbiter: two-requester (host / debug) config master for the west
// edge of tile 0's cfg chain. Round-robin grant, one outstanding read, read
// timeout with error response, and a saturating count of unexpected returns.
module glb_cfg_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0 (host)
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  // requester 1 (JTAG / debug)
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  // cfg chain
  output logic                  cfg_wr_en,
  output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [DATA_WIDTH-1:0] cfg_wr_data,
  output logic                  cfg_rd_en,
  output logic [ADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [DATA_WIDTH-1:0] cfg_rd_data,
  input  logic                  cfg_rd_data_valid,
  output logic [7:0]            stray_rd_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t                       r_state;
  logic                         r_last_grant;
  logic                         r_owner;
  logic [TW-1:0]                r_timer;
  logic [1:0]                   r_rsp_valid;
  logic [1:0][DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]                   r_rsp_err;
  logic                         r_wr_en;
  logic [ADDR_WIDTH-1:0]        r_wr_addr;
  logic [DATA_WIDTH-1:0]        r_wr_data;
  logic                         r_rd_en;
  logic [ADDR_WIDTH-1:0]        r_rd_addr;
  logic [7:0]                   r_stray;

  logic                  w_idle;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_idle = (r_state == S_IDLE);

  // Round-robin pick: a lone requester wins, contention goes to the one not granted last.
  always_comb begin
    w_grant = ~r_last_grant;
    if (req0_valid && !req1_valid)      w_grant = 1'b0;
    else if (req1_valid && !req0_valid) w_grant = 1'b1;
  end

  assign req0_ready  = w_idle & ~w_grant;
  assign req1_ready  = w_idle &  w_grant;
  assign w_accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_sel_write = w_grant ? req1_write : req0_write;
  assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;

  // Control FSM with all chain and response outputs registered; pulses default low
  // and data buses return to zero whenever their qualifier is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_timer      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_stray      <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      case (r_state)
        S_IDLE: begin
          // Nothing is outstanding, so any return here is unexpected (incl. late ones).
          if (cfg_rd_data_valid && r_stray != 8'hFF) r_stray <= r_stray + 8'd1;
          if (w_accept) begin
            r_last_grant <= w_grant;
            if (w_sel_write) begin
              r_wr_en              <= 1'b1;
              r_wr_addr            <= w_sel_addr;
              r_wr_data            <= w_sel_wdata;
              r_rsp_valid[w_grant] <= 1'b1;
            end else begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_sel_addr;
              r_owner   <= w_grant;
              r_timer   <= '0;
              r_state   <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          // Data beats the timeout when both land on the boundary cycle.
          if (cfg_rd_data_valid) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata[r_owner] <= cfg_rd_data;
            r_state              <= S_IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_err[r_owner]   <= 1'b1;
            r_state              <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp0_valid   = r_rsp_valid[0];
  assign rsp0_rdata   = r_rsp_rdata[0];
  assign rsp0_err     = r_rsp_err[0];
  assign rsp1_valid   = r_rsp_valid[1];
  assign rsp1_rdata   = r_rsp_rdata[1];
  assign rsp1_err     = r_rsp_err[1];
  assign cfg_wr_en    = r_wr_en;
  assign cfg_wr_addr  = r_wr_addr;
  assign cfg_wr_data  = r_wr_data;
  assign cfg_rd_en    = r_rd_en;
  assign cfg_rd_addr  = r_rd_addr;
  assign stray_rd_cnt = r_stray;

endmodule
